// File: rtl/uart_rx.sv
// UART receiver driven by an oversampling bclk tick: 2-FF rx synchroniser, mid-bit sampling,
// LSB-first assembly, one-entry valid/ready output register and frame/parity/overrun pulses.
module uart_rx #(
  parameter int SAMPLING   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(SAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLING / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(SAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic expected_parity(input logic [DATA_BITS-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic [2:0]           state_r;
  logic [2:0]           state_nxt_s;
  logic [TW-1:0]        tick_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bad_r;
  logic                 half_hit_s;
  logic                 full_hit_s;
  logic                 frame_done_s;

  assign half_hit_s = bclk && (tick_r == HALF_LAST);
  assign full_hit_s = bclk && (tick_r == FULL_LAST);

  // Next-state decode; frame_done_s marks the bclk cycle that samples the stop bit
  always_comb begin
    state_nxt_s  = state_r;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bclk && !rx_sync_r) state_nxt_s = START;
        else                    state_nxt_s = IDLE;
      end
      START: begin
        if (half_hit_s) state_nxt_s = rx_sync_r ? IDLE : DATA;
        else            state_nxt_s = START;
      end
      DATA: begin
        if (full_hit_s && (bit_idx_r == BIT_LAST)) state_nxt_s = (PARITY_EN != 0) ? PARITY : STOP;
        else                                        state_nxt_s = DATA;
      end
      PARITY: begin
        if (full_hit_s) state_nxt_s = STOP;
        else            state_nxt_s = PARITY;
      end
      STOP: begin
        if (full_hit_s) begin
          state_nxt_s  = IDLE;
          frame_done_s = 1'b1;
        end else begin
          state_nxt_s  = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Synchroniser, FSM, tick/bit counters and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      state_r   <= IDLE;
      busy      <= 1'b0;
      tick_r    <= {TW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_bad_r <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s != IDLE);
      // Restart the count on every state entry and after each full bit so sampling stays mid-bit
      if ((state_nxt_s != state_r) || full_hit_s) tick_r <= {TW{1'b0}};
      else if (bclk)                              tick_r <= tick_r + TW'(1);
      else                                        tick_r <= tick_r;
      if (state_r == START) begin
        bit_idx_r <= {BW{1'b0}};
        par_bad_r <= 1'b0;
      end else if ((state_r == DATA) && full_hit_s) begin
        bit_idx_r <= bit_idx_r + BW'(1);
        shift_r   <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
      end else if ((state_r == PARITY) && full_hit_s) begin
        par_bad_r <= (rx_sync_r != expected_parity(shift_r, ODD));
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end
  end

  // Output register, handshake and single-flag error reporting (frame > parity > overrun)
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= {DATA_BITS{1'b0}};
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      else                      rx_valid <= rx_valid;
      if (frame_done_s) begin
        if (!rx_sync_r) begin
          frame_error <= 1'b1;
        end else if (par_bad_r) begin
          parity_error <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        rx_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance plus even- and odd-parity instances on a shared rx line.
module tb_uart_rx;

  logic clk, reset, bclk, rx, rx_ready;
  logic [7:0] rx_data, rx_data_pe, rx_data_po;
  logic rx_valid, frame_error, parity_error, overrun, busy;
  logic rx_valid_pe, frame_error_pe, parity_error_pe, overrun_pe, busy_pe;
  logic rx_valid_po, frame_error_po, parity_error_po, overrun_po, busy_po;

  int pass_cnt = 0;
  int check_cnt = 0;

  int n_vrise, n_vcyc, n_fe, n_pe, n_ov;
  int n_vpe, n_perr_pe, n_vpo, n_perr_po;
  logic [7:0] last_data, data_pe, data_po;
  logic prev_v = 1'b0, prev_pe = 1'b0, prev_po = 1'b0;

  uart_rx #(.SAMPLING(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
    .parity_error(parity_error), .overrun(overrun), .busy(busy));

  uart_rx #(.SAMPLING(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(reset), .bclk(bclk), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data_pe), .rx_valid(rx_valid_pe), .frame_error(frame_error_pe),
    .parity_error(parity_error_pe), .overrun(overrun_pe), .busy(busy_pe));

  uart_rx #(.SAMPLING(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(reset), .bclk(bclk), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data_po), .rx_valid(rx_valid_po), .frame_error(frame_error_po),
    .parity_error(parity_error_po), .overrun(overrun_po), .busy(busy_po));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bclk: one-clk pulse every 4 clk, so one bit lasts 64 clk
  initial begin
    bclk = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bclk = 1'b1;
      @(negedge clk);
      bclk = 1'b0;
    end
  end

  // Event counters, sampled just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (rx_valid && !prev_v) begin n_vrise++; last_data = rx_data; end
    if (rx_valid) n_vcyc++;
    prev_v = rx_valid;
    n_fe += int'(frame_error);
    n_pe += int'(parity_error);
    n_ov += int'(overrun);
    if (rx_valid_pe && !prev_pe) begin n_vpe++; data_pe = rx_data_pe; end
    prev_pe = rx_valid_pe;
    n_perr_pe += int'(parity_error_pe);
    if (rx_valid_po && !prev_po) begin n_vpo++; data_po = rx_data_po; end
    prev_po = rx_valid_po;
    n_perr_po += int'(parity_error_po);
  end

  task automatic clear_counts();
    n_vrise = 0; n_vcyc = 0; n_fe = 0; n_pe = 0; n_ov = 0;
    n_vpe = 0; n_perr_pe = 0; n_vpo = 0; n_perr_po = 0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * 64) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    clear_counts();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", rx_data); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    check_cnt++; if ({frame_error, parity_error, overrun} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {frame_error, parity_error, overrun}); else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    rx_ready = 1'b1;
    idle_bits(2);
    clear_counts();
    send_bits({6'b111111, 1'b1, 8'h55, 1'b0}, 10);
    idle_bits(1);
    check_cnt++; if (n_vrise !== 1) $display("FAIL t1_valid_count got %0d want 1", n_vrise); else pass_cnt++;
    check_cnt++; if (n_vcyc !== 1) $display("FAIL t1_valid_cycles got %0d want 1", n_vcyc); else pass_cnt++;
    check_cnt++; if (last_data !== 8'h55) $display("FAIL t1_data got %h want 55", last_data); else pass_cnt++;
    check_cnt++; if (n_fe + n_pe + n_ov !== 0) $display("FAIL t1_flags got %0d want 0", n_fe + n_pe + n_ov); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL t1_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    check_cnt++; if (busy !== 1'b1) $display("FAIL t2_busy_start got %b want 1", busy); else pass_cnt++;
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL t2_busy_end got %b want 0", busy); else pass_cnt++;
    idle_bits(2);
    check_cnt++; if (n_vrise !== 0) $display("FAIL t2_valid got %0d want 0", n_vrise); else pass_cnt++;
    check_cnt++; if (n_fe + n_pe + n_ov !== 0) $display("FAIL t2_flags got %0d want 0", n_fe + n_pe + n_ov); else pass_cnt++;
  endtask

  task automatic test_frame_error();
    clear_counts();
    send_bits({6'b111111, 1'b0, 8'hA3, 1'b0}, 10);
    idle_bits(12);
    check_cnt++; if (n_fe !== 1) $display("FAIL t3_frame_error got %0d want 1", n_fe); else pass_cnt++;
    check_cnt++; if (n_vrise !== 0) $display("FAIL t3_no_valid got %0d want 0", n_vrise); else pass_cnt++;
    check_cnt++; if (n_pe + n_ov !== 0) $display("FAIL t3_other_flags got %0d want 0", n_pe + n_ov); else pass_cnt++;
    clear_counts();
    send_bits({6'b111111, 1'b1, 8'h3C, 1'b0}, 10);
    idle_bits(1);
    check_cnt++; if (n_vrise !== 1) $display("FAIL t3_recover_valid got %0d want 1", n_vrise); else pass_cnt++;
    check_cnt++; if (last_data !== 8'h3C) $display("FAIL t3_recover_data got %h want 3c", last_data); else pass_cnt++;
    check_cnt++; if (n_fe !== 0) $display("FAIL t3_recover_fe got %0d want 0", n_fe); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0;
    clear_counts();
    send_bits({6'b111111, 1'b1, 8'h12, 1'b0}, 10);
    send_bits({6'b111111, 1'b1, 8'h34, 1'b0}, 10);
    idle_bits(1);
    check_cnt++; if (rx_valid !== 1'b1) $display("FAIL t4_valid_held got %b want 1", rx_valid); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h12) $display("FAIL t4_data_held got %h want 12", rx_data); else pass_cnt++;
    check_cnt++; if (n_ov !== 1) $display("FAIL t4_overrun got %0d want 1", n_ov); else pass_cnt++;
    check_cnt++; if (n_fe + n_pe !== 0) $display("FAIL t4_other_flags got %0d want 0", n_fe + n_pe); else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge clk);
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL t4_valid_drop got %b want 0", rx_valid); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h12) $display("FAIL t4_data_after got %h want 12", rx_data); else pass_cnt++;
  endtask

  task automatic test_parity();
    idle_bits(12);
    clear_counts();
    send_bits({5'b11111, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle_bits(2);
    check_cnt++; if (n_vpe !== 1) $display("FAIL t5_even_ok_valid got %0d want 1", n_vpe); else pass_cnt++;
    check_cnt++; if (data_pe !== 8'h07) $display("FAIL t5_even_ok_data got %h want 07", data_pe); else pass_cnt++;
    check_cnt++; if (n_perr_pe !== 0) $display("FAIL t5_even_ok_perr got %0d want 0", n_perr_pe); else pass_cnt++;
    clear_counts();
    send_bits({5'b11111, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle_bits(12);
    check_cnt++; if (n_perr_pe !== 1) $display("FAIL t5_even_bad_perr got %0d want 1", n_perr_pe); else pass_cnt++;
    check_cnt++; if (n_vpe !== 0) $display("FAIL t5_even_bad_valid got %0d want 0", n_vpe); else pass_cnt++;
    check_cnt++; if (n_vpo !== 1) $display("FAIL t5_odd_valid got %0d want 1", n_vpo); else pass_cnt++;
    check_cnt++; if (data_po !== 8'h07) $display("FAIL t5_odd_data got %h want 07", data_po); else pass_cnt++;
    check_cnt++; if (n_perr_po !== 0) $display("FAIL t5_odd_perr got %0d want 0", n_perr_po); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    clear_counts();
    send_bits({6'b111111, 1'b1, 8'hC3, 1'b0}, 4);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    check_cnt++; if (busy !== 1'b1) $display("FAIL t6_busy_before got %b want 1", busy); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    check_cnt++; if (busy !== 1'b0) $display("FAIL t6_busy_reset got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h00) $display("FAIL t6_data_reset got %h want 00", rx_data); else pass_cnt++;
    check_cnt++; if ({rx_valid, frame_error, parity_error, overrun} !== 4'b0000)
      $display("FAIL t6_outs_reset got %b want 0000", {rx_valid, frame_error, parity_error, overrun}); else pass_cnt++;
    idle_bits(12);
    check_cnt++; if (n_vrise !== 0) $display("FAIL t6_aborted_valid got %0d want 0", n_vrise); else pass_cnt++;
    clear_counts();
    send_bits({6'b111111, 1'b1, 8'hC3, 1'b0}, 10);
    idle_bits(1);
    check_cnt++; if (n_vrise !== 1) $display("FAIL t6_clean_valid got %0d want 1", n_vrise); else pass_cnt++;
    check_cnt++; if (last_data !== 8'hC3) $display("FAIL t6_clean_data got %h want c3", last_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_parity();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
